// File: rtl/rca_multiword_seq.sv
// Wide add/subtract done serially on one N-bit ripple slice, LS word first; out_valid WORDS cycles after accept.
// Result held in DONE until out_ready; in_ready only in IDLE. `RCA_SEQ_OVF_EN adds signed-overflow output ovf.
module rca_multiword_seq #(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WORDS-1:0] a,
   input  logic [N*WORDS-1:0] b,
   input  logic               c_in,
   input  logic               sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*WORDS-1:0] s,
   output logic               c_out,
   output logic               busy
`ifdef RCA_SEQ_OVF_EN
   ,
   output logic               ovf
`endif
);
   localparam int W  = N * WORDS;
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] KLAST = KW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic            cy_q, cy_d;
   logic [W-1:0]    opa_q, opa_d;
   logic [W-1:0]    opb_q, opb_d;
   logic [W-1:0]    s_q, s_d;
   logic            cout_q, cout_d;
   logic [N-1:0]    sl_a, sl_b, sl_s;
   logic            sl_co;
`ifdef RCA_SEQ_OVF_EN
   logic            sl_cm;
   logic            ovf_q, ovf_d;
`endif

   assign sl_a = opa_q[k_q*N +: N];
   assign sl_b = opb_q[k_q*N +: N];

   RCA_Nbit #(.N(N)) u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (cy_q),
      .s    (sl_s),
`ifdef RCA_SEQ_OVF_EN
      .c_msb(sl_cm),
`endif
      .cout (sl_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         cy_q    <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cy_q    <= cy_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
`ifdef RCA_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cy_d    = cy_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      s_d     = s_q;
      cout_d  = cout_q;
`ifdef RCA_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Subtract as a + ~b + ~borrow so the slice only ever adds.
               opa_d   = a;
               opb_d   = sub ? ~b : b;
               cy_d    = sub ? ~c_in : c_in;
               k_d     = '0;
               s_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[k_q*N +: N] = sl_s;
            cy_d = sl_co;
            k_d  = k_q + KW'(1);
            if (k_q == KLAST) begin
               cout_d  = sl_co;
`ifdef RCA_SEQ_OVF_EN
               ovf_d   = sl_cm ^ sl_co;
`endif
               k_d     = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign s         = s_q;
   assign c_out     = cout_q;
`ifdef RCA_SEQ_OVF_EN
   assign ovf       = ovf_q;
`endif
endmodule

// N-bit ripple-carry adder slice; c_msb is the carry into the top bit (overflow tap).
module RCA_Nbit #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
`ifdef RCA_SEQ_OVF_EN
   output logic         c_msb,
`endif
   output logic         cout
);
   logic [N:0] c;

   assign c[0] = cin;
   for (genvar i = 0; i < N; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign cout = c[N];
`ifdef RCA_SEQ_OVF_EN
   assign c_msb = c[N-1];
`endif
endmodule

// File: tb/tb_rca_multiword_seq.sv
// Bench for rca_multiword_seq (N=4, WORDS=4): vector table, handshake corner sequences, randomized ops vs model.
module tb_rca_multiword_seq;
   localparam int N = 4;
   localparam int WORDS = 4;
   localparam int W = N * WORDS;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         c_in = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] s;
   logic         c_out;
   logic         busy;
`ifdef RCA_SEQ_OVF_EN
   logic         ovf;
`endif

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   rca_multiword_seq #(.N(N), .WORDS(WORDS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .c_in     (c_in),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .s        (s),
      .c_out    (c_out),
`ifdef RCA_SEQ_OVF_EN
      .ovf      (ovf),
`endif
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] exp_s;
      logic         exp_c;
      logic         exp_o;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the full-width operands.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc, input logic ms,
                        output logic [W-1:0] rs, output logic rc, output logic ro);
      int ur, sr, sa, sb;
      sa = $signed(ma);
      sb = $signed(mb);
      if (ms) begin
         ur = int'(ma) - int'(mb) - int'(mc);
         sr = sa - sb - int'(mc);
         rc = (ur >= 0);
      end else begin
         ur = int'(ma) + int'(mb) + int'(mc);
         sr = sa + sb + int'(mc);
         rc = (ur > 65535);
      end
      rs = ur[W-1:0];
      ro = (sr > 32767) || (sr < -32768);
   endtask

   // Called at a negedge; returns at the negedge where out_valid is first seen.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts,
                         input bit noise, output logic [W-1:0] rs, output logic rc, output logic ro,
                         output int lat, output int acc);
      int guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL accept_timeout: in_ready never rose");
      end
      a = ta; b = tb_; c_in = tc; sub = ts; in_valid = 1'b1;
      @(posedge clk);
      #1 acc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      chk("busy_in_run", busy, 1);
      chk("in_ready_in_run", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (noise) begin
            in_valid = ~in_valid;
            a = $urandom; b = $urandom;
         end
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         n_cmp++; n_fail++;
         $display("FAIL done_timeout: out_valid never rose");
      end
      rs = s; rc = c_out;
`ifdef RCA_SEQ_OVF_EN
      ro = ovf;
`else
      ro = 1'b0;
`endif
   endtask

   initial begin
      logic [W-1:0] rs, es, hs;
      logic         rc, ro, ec, eo;
      int           lat, acc1, acc2;

      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{16'h1234, 16'h0235, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0};
      vecs[2] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      vecs[3] = '{16'h00F0, 16'h0F0F, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

      // Reset state
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_s", s, 0);
      chk("rst_c_out", c_out, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_valid_in_ready", in_ready, 1);
      chk("idle_no_valid_busy", busy, 0);

      // Directed vector table with out_ready held high
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b0, rs, rc, ro, lat, acc1);
         chk($sformatf("vec%0d_s", i), rs, vecs[i].exp_s);
         chk($sformatf("vec%0d_c_out", i), rc, vecs[i].exp_c);
         chk($sformatf("vec%0d_latency", i), lat, WORDS);
`ifdef RCA_SEQ_OVF_EN
         chk($sformatf("vec%0d_ovf", i), ro, vecs[i].exp_o);
`endif
      end

      // Backpressure with in_valid noise during RUN and DONE
      @(negedge clk);
      out_ready = 1'b0;
      run_op(16'h00F0, 16'h0F0F, 1'b1, 1'b0, 1'b1, rs, rc, ro, lat, acc1);
      chk("bp_s", rs, 16'h1000);
      chk("bp_c_out", rc, 0);
      chk("bp_latency", lat, WORDS);
      for (int i = 0; i < 3; i++) begin
         in_valid = ~in_valid; a = $urandom; b = $urandom;
         @(negedge clk);
         chk("bp_hold_out_valid", out_valid, 1);
         chk("bp_hold_in_ready", in_ready, 0);
         chk("bp_hold_s", s, 16'h1000);
         chk("bp_hold_c_out", c_out, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_taken_out_valid", out_valid, 0);
      chk("bp_taken_in_ready", in_ready, 1);
      chk("bp_taken_s_kept", s, 16'h1000);
      chk("bp_taken_busy", busy, 0);

      // Back-to-back with out_ready tied high
      run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, rs, rc, ro, lat, acc1);
      chk("b2b_first_s", rs, 16'h3333);
      run_op(16'h0100, 16'h0200, 1'b0, 1'b1, 1'b0, rs, rc, ro, lat, acc2);
      chk("b2b_second_s", rs, 16'hFF00);
      chk("b2b_second_c_out", rc, 0);
      chk("b2b_accept_spacing", acc2 - acc1, WORDS + 2);

      // Reset in the middle of RUN (k==2)
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrun_partial_s", s, 16'h00FE);
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_in_ready", in_ready, 1);
      chk("midrun_rst_out_valid", out_valid, 0);
      chk("midrun_rst_s", s, 0);
      chk("midrun_rst_c_out", c_out, 0);
      chk("midrun_rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, rs, rc, ro, lat, acc1);
      chk("post_rst_s", rs, 16'h0007);
      chk("post_rst_c_out", rc, 0);

      // Randomized operations with random consumer stalls
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         logic rcin, rsub;
         int stall;
         ra = $urandom; rb = $urandom; rcin = $urandom_range(0, 1); rsub = $urandom_range(0, 1);
         stall = $urandom_range(0, 3);
         @(negedge clk);
         out_ready = (stall == 0);
         model(ra, rb, rcin, rsub, es, ec, eo);
         run_op(ra, rb, rcin, rsub, 1'b0, rs, rc, ro, lat, acc1);
         chk($sformatf("rnd%0d_s", i), rs, es);
         chk($sformatf("rnd%0d_c_out", i), rc, ec);
         chk($sformatf("rnd%0d_latency", i), lat, WORDS);
`ifdef RCA_SEQ_OVF_EN
         chk($sformatf("rnd%0d_ovf", i), ro, eo);
`endif
         hs = rs;
         for (int j = 0; j < stall; j++) begin
            @(negedge clk);
            chk($sformatf("rnd%0d_stall_s", i), s, hs);
            chk($sformatf("rnd%0d_stall_out_valid", i), out_valid, 1);
         end
         out_ready = 1'b1;
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
